// File: rtl/coeff_pkg.sv
// rtl/coeff_pkg.sv - shared types and default sizes for the coefficient receiver
package coeff_pkg;

    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_NUM_COEFF = 4;
    localparam int DEFAULT_WRITE_LAT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } rx_state_t;

    typedef logic [DEFAULT_DATA_W-1:0] coeff_t;

endpackage

// File: rtl/coeff_shadow_bank.sv
// rtl/coeff_shadow_bank.sv - shadow/active coefficient storage with valid mask and atomic commit
module coeff_shadow_bank #(
    parameter int DATA_W    = 16,
    parameter int NUM_COEFF = 4,
    parameter int IDX_W     = $clog2(NUM_COEFF)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        commit,
    input  logic                        clear,
    output logic [NUM_COEFF-1:0]        mask,
    output logic [NUM_COEFF*DATA_W-1:0] coeffs_active
);

    logic [DATA_W-1:0] shadow [NUM_COEFF];
    logic [DATA_W-1:0] active [NUM_COEFF];

    // Shadow writes fill the mask; commit copies the whole shadow bank in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            mask <= '0;
        end else begin
            if (commit) begin
                for (int i = 0; i < NUM_COEFF; i++) begin
                    active[i] <= shadow[i];
                end
                mask <= '0;
            end else if (clear) begin
                mask <= '0;
            end else if (wr_en) begin
                shadow[wr_idx] <= wr_data;
                mask[wr_idx]   <= 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_COEFF; g++) begin : g_flat
            assign coeffs_active[g*DATA_W +: DATA_W] = active[g];
        end
    endgenerate

endmodule

// File: rtl/coefficient_receiver.sv
// rtl/coefficient_receiver.sv - coefficient-load responder FSM; COEFF_ORDER_CHECK_EN enables strict index order
module coefficient_receiver
    import coeff_pkg::*;
#(
    parameter int  DATA_W    = DEFAULT_DATA_W,
    parameter int  NUM_COEFF = DEFAULT_NUM_COEFF,
    parameter int  WRITE_LAT = DEFAULT_WRITE_LAT,
    localparam int IDX_W     = $clog2(NUM_COEFF)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_coeff,
    input  logic [IDX_W-1:0]            coefficient_num,
    input  logic [DATA_W-1:0]           coeff_data,
    output logic                        modwait,
    output logic [NUM_COEFF*DATA_W-1:0] coeffs_active,
    output logic                        set_loaded,
    output logic                        load_drop,
    output logic                        coeff_err
);

    localparam int CNT_W = $clog2(WRITE_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WRITE_LAT - 1);

    rx_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_COEFF-1:0]  mask;
    logic                  wr_en;
    logic                  clear;
    logic                  commit;

`ifdef COEFF_ORDER_CHECK_EN
    logic [IDX_W-1:0]      exp_idx;
    logic                  err_q;
`endif

    // An accepted strobe either writes the shadow bank or, on an order violation, clears the partial set.
    always_comb begin
        wr_en = 1'b0;
        clear = 1'b0;
        if (state == IDLE && load_coeff) begin
`ifdef COEFF_ORDER_CHECK_EN
            if (coefficient_num != exp_idx) begin
                clear = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
`else
            wr_en = 1'b1;
`endif
        end
    end

    assign commit = (state == COMMIT);

    // Handshake FSM: busy counter, registered modwait and one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            modwait    <= 1'b0;
            set_loaded <= 1'b0;
            load_drop  <= 1'b0;
        end else begin
            set_loaded <= 1'b0;
            load_drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_coeff) begin
                        state   <= WRITE;
                        cnt     <= CNT_INIT;
                        modwait <= 1'b1;
                    end
                end
                WRITE: begin
                    if (load_coeff) begin
                        load_drop <= 1'b1;
                    end
                    if (cnt == '0) begin
                        if (&mask) begin
                            state <= COMMIT;
                        end else begin
                            state   <= IDLE;
                            modwait <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                COMMIT: begin
                    if (load_coeff) begin
                        load_drop <= 1'b1;
                    end
                    state      <= IDLE;
                    modwait    <= 1'b0;
                    set_loaded <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    modwait <= 1'b0;
                end
            endcase
        end
    end

`ifdef COEFF_ORDER_CHECK_EN
    // Expected-index tracking; any out-of-order strobe latches a sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_idx <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            exp_idx <= '0;
        end else if (clear) begin
            exp_idx <= '0;
            err_q   <= 1'b1;
        end else if (wr_en) begin
            exp_idx <= exp_idx + 1'b1;
        end
    end

    assign coeff_err = err_q;
`else
    assign coeff_err = 1'b0;
`endif

    coeff_shadow_bank #(
        .DATA_W    (DATA_W),
        .NUM_COEFF (NUM_COEFF),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_idx        (coefficient_num),
        .wr_data       (coeff_data),
        .commit        (commit),
        .clear         (clear),
        .mask          (mask),
        .coeffs_active (coeffs_active)
    );

endmodule

// File: tb/tb_coefficient_receiver.sv
// tb/tb_coefficient_receiver.sv - scoreboard bench for coefficient_receiver
module tb_coefficient_receiver;

    logic        clk;
    logic        reset;
    logic        load_coeff;
    logic [1:0]  coefficient_num;
    logic [15:0] coeff_data;
    logic        modwait;
    logic [63:0] coeffs_active;
    logic        set_loaded;
    logic        load_drop;
    logic        coeff_err;

    int checks;
    int errors;
    int sl_count;
    int drop_count;
    logic [63:0] exp_q[$];

    coefficient_receiver dut (
        .clk             (clk),
        .reset           (reset),
        .load_coeff      (load_coeff),
        .coefficient_num (coefficient_num),
        .coeff_data      (coeff_data),
        .modwait         (modwait),
        .coeffs_active   (coeffs_active),
        .set_loaded      (set_loaded),
        .load_drop       (load_drop),
        .coeff_err       (coeff_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every commit pulse must match the oldest expected set.
    always @(negedge clk) begin
        if (!reset && set_loaded) begin
            sl_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got %h, no set expected", coeffs_active);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (coeffs_active !== e) begin
                    errors++;
                    $display("FAIL commit_data: got %h expected %h", coeffs_active, e);
                end
            end
        end
        if (!reset && load_drop) drop_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    task automatic strobe(input logic [1:0] idx, input logic [15:0] data, output int busy);
        int g;
        g = 0;
        while (modwait && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g == 50) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: modwait stuck at %b, required 0", modwait);
        end
        load_coeff      = 1'b1;
        coefficient_num = idx;
        coeff_data      = data;
        @(negedge clk);
        load_coeff = 1'b0;
        busy = 0;
        while (modwait && busy < 20) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({modwait, set_loaded, load_drop, coeff_err} !== 4'b0000 || coeffs_active !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: modwait/set/drop/err=%b%b%b%b active=%h, required all 0",
                     modwait, set_loaded, load_drop, coeff_err, coeffs_active);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_set();
        int busy;
        int sl0;
        int exp_busy[4] = '{2, 2, 2, 3};
        logic [63:0] e;
        e = {16'h0404, 16'h0303, 16'h0202, 16'h0101};
        sl0 = sl_count;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(e);
            strobe(2'(i), 16'(16'h0101 * (i + 1)), busy);
            checks++;
            if (busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL full_set_busy%0d: got %0d cycles, required %0d", i, busy, exp_busy[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (sl_count !== sl0 + 1) begin
            errors++;
            $display("FAIL full_set_pulses: got %0d, required 1", sl_count - sl0);
        end
        checks++;
        if (coeffs_active !== e) begin
            errors++;
            $display("FAIL full_set_active: got %h, required %h", coeffs_active, e);
        end
    endtask

    task automatic test_busy_drop();
        int b;
        int busy;
        int d0;
        d0 = drop_count;
        load_coeff      = 1'b1;
        coefficient_num = 2'd0;
        coeff_data      = 16'h1111;
        @(negedge clk);
        checks++;
        if (modwait !== 1'b1) begin
            errors++;
            $display("FAIL drop_modwait: got %b, required 1", modwait);
        end
        coeff_data = 16'h2222;
        @(negedge clk);
        load_coeff = 1'b0;
        checks++;
        if (load_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse: got %b, required 1", load_drop);
        end
        b = 1;
        while (modwait && b < 20) begin
            b++;
            @(negedge clk);
        end
        checks++;
        if (b !== 2) begin
            errors++;
            $display("FAIL drop_busy: got %0d cycles, required 2", b);
        end
        checks++;
        if (drop_count !== d0 + 1) begin
            errors++;
            $display("FAIL drop_count: got %0d, required 1", drop_count - d0);
        end
        strobe(2'd1, 16'h1212, busy);
        strobe(2'd2, 16'h1313, busy);
        exp_q.push_back({16'h1414, 16'h1313, 16'h1212, 16'h1111});
        strobe(2'd3, 16'h1414, busy);
        @(negedge clk);
        checks++;
        if (coeffs_active[15:0] !== 16'h1111) begin
            errors++;
            $display("FAIL drop_shadow0: got %h, required 1111", coeffs_active[15:0]);
        end
    endtask

    task automatic test_atomic();
        int busy;
        logic [63:0] a;
        logic [63:0] bset;
        a    = {16'hA004, 16'hA003, 16'hA002, 16'hA001};
        bset = {16'hB004, 16'hB003, 16'hB002, 16'hB001};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(a);
            strobe(2'(i), a[i*16 +: 16], busy);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            strobe(2'(i), bset[i*16 +: 16], busy);
            checks++;
            if (coeffs_active !== a) begin
                errors++;
                $display("FAIL atomic_hold%0d: got %h, required %h", i, coeffs_active, a);
            end
        end
        exp_q.push_back(bset);
        strobe(2'd3, bset[63:48], busy);
        checks++;
        if (coeffs_active !== bset) begin
            errors++;
            $display("FAIL atomic_switch: got %h, required %h", coeffs_active, bset);
        end
    endtask

    task automatic test_reset_mid();
        int busy;
        int sl0;
        logic [1:0] ord[4];
        logic [63:0] e;
        e = {16'hC004, 16'hC003, 16'hC002, 16'hC001};
`ifdef COEFF_ORDER_CHECK_EN
        ord = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
        ord = '{2'd2, 2'd3, 2'd0, 2'd1};
`endif
        strobe(2'd0, 16'hDEAD, busy);
        load_coeff      = 1'b1;
        coefficient_num = 2'd1;
        coeff_data      = 16'hBEEF;
        @(negedge clk);
        load_coeff = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (modwait !== 1'b0 || coeffs_active !== 64'h0) begin
            errors++;
            $display("FAIL midreset_clear: modwait=%b active=%h, required 0 and 0", modwait, coeffs_active);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sl0 = sl_count;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(e);
            strobe(ord[i], e[ord[i]*16 +: 16], busy);
            checks++;
            if (busy !== ((i == 3) ? 3 : 2)) begin
                errors++;
                $display("FAIL midreset_busy%0d: got %0d, required %0d", i, busy, (i == 3) ? 3 : 2);
            end
        end
        @(negedge clk);
        checks++;
        if (sl_count !== sl0 + 1) begin
            errors++;
            $display("FAIL midreset_pulses: got %0d, required 1", sl_count - sl0);
        end
    endtask

    task automatic test_order();
        int busy;
        int sl0;
        logic [63:0] e;
        e = {16'hD004, 16'hD003, 16'hD002, 16'hD001};
        checks++;
        if (coeff_err !== 1'b0) begin
            errors++;
            $display("FAIL order_err_init: got %b, required 0", coeff_err);
        end
`ifdef COEFF_ORDER_CHECK_EN
        sl0 = sl_count;
        strobe(2'd0, 16'h5555, busy);
        strobe(2'd2, 16'h6666, busy);
        checks++;
        if (busy !== 2) begin
            errors++;
            $display("FAIL order_bad_busy: got %0d, required 2", busy);
        end
        checks++;
        if (coeff_err !== 1'b1 || sl_count !== sl0) begin
            errors++;
            $display("FAIL order_bad: err=%b pulses=%0d, required 1 and 0", coeff_err, sl_count - sl0);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(e);
            strobe(2'(i), e[i*16 +: 16], busy);
        end
        @(negedge clk);
        checks++;
        if (coeff_err !== 1'b1 || sl_count !== sl0 + 1) begin
            errors++;
            $display("FAIL order_sticky: err=%b pulses=%0d, required 1 and 1", coeff_err, sl_count - sl0);
        end
`else
        begin
            logic [1:0] ord[4];
            int exp_busy[4] = '{2, 2, 2, 3};
            ord = '{2'd3, 2'd1, 2'd0, 2'd2};
            sl0 = sl_count;
            for (int i = 0; i < 4; i++) begin
                if (i == 3) exp_q.push_back(e);
                strobe(ord[i], e[ord[i]*16 +: 16], busy);
                checks++;
                if (busy !== exp_busy[i]) begin
                    errors++;
                    $display("FAIL any_order_busy%0d: got %0d, required %0d", i, busy, exp_busy[i]);
                end
            end
            @(negedge clk);
            checks++;
            if (coeff_err !== 1'b0 || sl_count !== sl0 + 1) begin
                errors++;
                $display("FAIL any_order: err=%b pulses=%0d, required 0 and 1", coeff_err, sl_count - sl0);
            end
        end
`endif
    endtask

    task automatic test_rewrite();
`ifndef COEFF_ORDER_CHECK_EN
        int busy;
        int sl0;
        logic [63:0] e;
        e = {16'hE003, 16'hE002, 16'hBBBB, 16'hE000};
        sl0 = sl_count;
        strobe(2'd1, 16'hAAAA, busy);
        strobe(2'd1, 16'hBBBB, busy);
        checks++;
        if (busy !== 2 || sl_count !== sl0) begin
            errors++;
            $display("FAIL rewrite_mask: busy=%0d pulses=%0d, required 2 and 0", busy, sl_count - sl0);
        end
        strobe(2'd0, 16'hE000, busy);
        strobe(2'd2, 16'hE002, busy);
        exp_q.push_back(e);
        strobe(2'd3, 16'hE003, busy);
        @(negedge clk);
        checks++;
        if (sl_count !== sl0 + 1 || coeffs_active[31:16] !== 16'hBBBB) begin
            errors++;
            $display("FAIL rewrite_commit: pulses=%0d coeff1=%h, required 1 and BBBB",
                     sl_count - sl0, coeffs_active[31:16]);
        end
`endif
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        sl_count        = 0;
        drop_count      = 0;
        reset           = 1'b1;
        load_coeff      = 1'b0;
        coefficient_num = 2'd0;
        coeff_data      = 16'h0;
        test_reset();
        test_full_set();
        test_busy_drop();
        test_atomic();
        test_reset_mid();
        test_order();
        test_rewrite();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_commits: %0d expected sets never committed, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
